dac_underflow_guard: RTL and testbench
======================================

# dac_underflow_guard

Parametrised DAC-side output stage placed between the TX hold/timing logic and the RF DAC FIFO. It forwards samples for `NUM_CHAN` I/Q channels and zeroes the lanes of disabled channels. When the downstream FIFO runs low it inserts pad samples, either zero or a repeat of the last sample, so the FIFO never truly underflows and sample counting stays exact. Each starvation inside an active transmission is reported once, as a single-cycle pulse, and is also counted in a saturating counter.

## Interface
Parameters:
- `NUM_CHAN`, 2: number of I/Q channels. Each channel is 32 bits (I in [15:0], Q in [31:16]). `DATA_WIDTH` = 32*`NUM_CHAN`.
- `ROOM_WIDTH`, 10: width of the downstream FIFO room count.
- `ROOM_THRESH`, 504: padding is requested when `m_room` >= `ROOM_THRESH`.
- `CNT_WIDTH`, 16: width of the underflow event counter.

Ports (all synchronous to `clk`):
- `clk`, in, 1: the only clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `cfg_chan_en`, in, `NUM_CHAN`: channel enables. A lane whose bit is 0 outputs 0.
- `cfg_pad_repeat`, in, 1: selects the pad source. 0 = zero, 1 = repeat the last sample.
- `cfg_count_clear`, in, 1: synchronous clear of `status_underflow_count`.
- `tx_active`, in, 1: high while a transmission is in progress.
- `s_valid`, in, 1: source sample valid.
- `s_ready`, out, 1: source ready.
- `s_data`, in, `DATA_WIDTH`: source sample.
- `m_ready`, in, 1: DAC FIFO ready.
- `m_valid`, out, 1: output sample valid.
- `m_data`, out, `DATA_WIDTH`: output sample.
- `m_room`, in, `ROOM_WIDTH`: free entries in the DAC FIFO.
- `dac_underflow`, out, 1: one-cycle pulse per starvation event.
- `status_underflow_count`, out, `CNT_WIDTH`: saturating count of starvation events.
- `status_starved`, out, 1: high while the state machine is in STARVE.

## Operation
- `pad_req` is a register: `pad_req` <= (`m_room` >= `ROOM_THRESH`).
- Output handshake:
  - `s_ready` = `m_ready`.
  - `m_valid` = `s_valid` | `pad_req`.
  - When `s_valid` is high, `m_data` = masked `s_data`; otherwise `m_data` = pad sample.
  - A source sample always wins over a pad.
- Lane mask: lane c (bits [32c+31:32c]) is forced to 0 when `cfg_chan_en`[c] = 0. The mask applies to source and pad data alike.
- Last-sample register `last_q`:
  - Loads the masked `s_data` on each `s_valid` & `m_ready` transfer while the state is not IDLE.
  - Cleared to 0 in IDLE.
- Pad sample = `cfg_pad_repeat` ? `last_q` : 0. Outside a transmission the pad is therefore always 0.
- State machine, IDLE/RUN/STARVE:
  - Any state -> IDLE when `tx_active` = 0. This transition has the highest priority.
  - IDLE -> RUN when `tx_active` = 1.
  - RUN -> STARVE when `pad_req` & ~`s_valid` & `m_ready` (a pad was inserted mid-transmission).
  - STARVE -> RUN on an `s_valid` & `m_ready` transfer.
  - Pads issued in IDLE are not events.
- Event handling on the RUN -> STARVE transition:
  - `dac_underflow` is registered high for exactly one cycle.
  - `status_underflow_count` increments and saturates at all-ones.
  - Further pads while in STARVE raise no new events.
- `cfg_count_clear` takes priority over a same-cycle increment; that increment is lost.
- Reset (asynchronous): state = IDLE; `pad_req`, `last_q`, `dac_underflow`, `status_underflow_count` and `status_starved` = 0. Consequently `m_valid` = `s_valid` and `m_data` = masked `s_data` or 0.

## Timing
- The data path is combinational: `s_data` -> `m_data` has zero latency and `s_ready` follows `m_ready` combinationally.
- `m_room` crossing the threshold affects `m_valid` one cycle later, through `pad_req`.
- `dac_underflow`, `status_starved` and the counter update in the cycle after the qualifying edge.
- `tx_active` falling returns the state to IDLE on the next edge. `last_q` is zero from that cycle onwards.
- Reset asserted mid-transmission: all outputs clear immediately, with no pulse emitted. After release the block starts in IDLE.

## Test plan
- Passthrough and masking: `NUM_CHAN`=2, `cfg_chan_en`=2'b01, stream 0xAAAA_BBBB_1234_5678 -> `m_data`=0x0000_0000_1234_5678 on the same cycle; no pads while `m_room`<504.
- Starvation: `tx_active`=1, `cfg_pad_repeat`=0, `s_valid`=0, `m_room`=510 for 5 cycles -> `m_valid`=1 with `m_data`=0 from the cycle after `m_room` rises; exactly one `dac_underflow` pulse; count=1.
- Repeat pad: last transferred sample 0x0001_0002_0003_0004, `cfg_pad_repeat`=1, starve -> pads equal 0x0001_0002_0003_0004. After `tx_active`=0, pads equal 0.
- Recovery and re-entry: starve, transfer one sample, starve again -> two pulses, count=2, `status_starved` toggles 1->0->1.
- Saturation and clear: `CNT_WIDTH`=2, 5 events -> count holds at 3. `cfg_count_clear` on the same cycle as an event -> count=0.
- Asynchronous reset mid-STARVE: `resetn` low between clock edges -> `status_starved`, count and `last_q` read 0 immediately; no `dac_underflow` pulse follows reset release.

Source files
------------

// File: rtl/dac_underflow_guard.sv
// DAC-side output stage: forwards masked I/Q samples and inserts pad samples when the
// downstream FIFO runs low. Each starvation inside a transmission is flagged once and counted.
module dac_underflow_guard #(
  parameter int unsigned NUM_CHAN    = 2,
  parameter int unsigned ROOM_WIDTH  = 10,
  parameter int unsigned ROOM_THRESH = 504,
  parameter int unsigned CNT_WIDTH   = 16,
  localparam int unsigned DATA_WIDTH = 32 * NUM_CHAN
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_CHAN-1:0]   cfg_chan_en,
  input  logic                  cfg_pad_repeat,
  input  logic                  cfg_count_clear,
  input  logic                  tx_active,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic [ROOM_WIDTH-1:0] m_room,
  output logic                  dac_underflow,
  output logic [CNT_WIDTH-1:0]  status_underflow_count,
  output logic                  status_starved
);

  typedef enum logic [1:0] {StIdle, StRun, StStarve} state_e;

  state_e                state_q, state_d;
  logic                  pad_req_q;
  logic [DATA_WIDTH-1:0] last_q;
  logic                  underflow_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] pad_data;
  logic                  xfer;
  logic                  starve_entry;

  // Expand per-channel enables into a full-width lane mask
  always_comb begin
    lane_mask = '0;
    for (int unsigned c = 0; c < NUM_CHAN; c++) begin
      lane_mask[32*c +: 32] = {32{cfg_chan_en[c]}};
    end
  end

  // Combinational data path; a source sample always beats a pad
  always_comb begin
    pad_data = cfg_pad_repeat ? last_q : '0;
    s_ready  = m_ready;
    m_valid  = s_valid | pad_req_q;
    m_data   = (s_valid ? s_data : pad_data) & lane_mask;
    xfer     = s_valid & m_ready;
    // Pad actually taken by the FIFO while running: a real starvation event
    starve_entry = (state_q == StRun) & tx_active & pad_req_q & ~s_valid & m_ready;
  end

  // Next-state logic; dropping tx_active wins over everything
  always_comb begin
    state_d = state_q;
    if (!tx_active) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StRun;
        StRun:    if (pad_req_q && !s_valid && m_ready) state_d = StStarve;
        StStarve: if (xfer) state_d = StRun;
        default:  state_d = StIdle;
      endcase
    end
  end

  // State, pad request and last-sample registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      pad_req_q <= 1'b0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      pad_req_q <= (m_room >= ROOM_WIDTH'(ROOM_THRESH));
      // Clear as soon as the block heads to IDLE so repeat pads never leak out of a burst
      if (state_q == StIdle || !tx_active) begin
        last_q <= '0;
      end else if (xfer) begin
        last_q <= s_data & lane_mask;
      end
    end
  end

  // Event pulse and saturating counter; clear beats a same-cycle increment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      underflow_q <= 1'b0;
      count_q     <= '0;
    end else begin
      underflow_q <= starve_entry;
      if (cfg_count_clear) begin
        count_q <= '0;
      end else if (starve_entry && (count_q != {CNT_WIDTH{1'b1}})) begin
        count_q <= count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign dac_underflow          = underflow_q;
  assign status_underflow_count = count_q;
  assign status_starved         = (state_q == StStarve);

endmodule

// File: tb/tb_dac_underflow_guard.sv
// Directed bench: stimulus pushes expected output samples, a negedge monitor pops and compares.
module tb_dac_underflow_guard;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  cfg_chan_en;
  logic        cfg_pad_repeat;
  logic        cfg_count_clear;
  logic        tx_active;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        m_ready;
  logic        m_valid;
  logic [63:0] m_data;
  logic [9:0]  m_room;
  logic        dac_underflow;
  logic [15:0] status_underflow_count;
  logic        status_starved;

  logic        sat_s_ready;
  logic        sat_m_valid;
  logic [63:0] sat_m_data;
  logic        sat_underflow;
  logic [1:0]  sat_count;
  logic        sat_starved;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  dac_underflow_guard dut (
    .clk(clk), .resetn(resetn), .cfg_chan_en(cfg_chan_en), .cfg_pad_repeat(cfg_pad_repeat),
    .cfg_count_clear(cfg_count_clear), .tx_active(tx_active), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data),
    .m_room(m_room), .dac_underflow(dac_underflow),
    .status_underflow_count(status_underflow_count), .status_starved(status_starved)
  );

  // Narrow counter instance for saturation; shares all stimulus with the main one
  dac_underflow_guard #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .resetn(resetn), .cfg_chan_en(cfg_chan_en), .cfg_pad_repeat(cfg_pad_repeat),
    .cfg_count_clear(cfg_count_clear), .tx_active(tx_active), .s_valid(s_valid),
    .s_ready(sat_s_ready), .s_data(s_data), .m_ready(m_ready), .m_valid(sat_m_valid),
    .m_data(sat_m_data), .m_room(m_room), .dac_underflow(sat_underflow),
    .status_underflow_count(sat_count), .status_starved(sat_starved)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; ev says whether an output sample is expected this cycle
  task automatic step(input logic sv, input logic [63:0] sd, input logic [9:0] room,
                      input logic ev, input logic [63:0] ed);
    s_valid = sv;
    s_data  = sd;
    m_room  = room;
    if (ev) exp_q.push_back(ed);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented output sample must match the next expected one
  always @(negedge clk) begin
    if (resetn && m_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_m_valid: got data %h expected no output", m_data);
      end else begin
        chk("m_data", m_data, exp_q.pop_front());
      end
    end
    if (resetn) chk("s_ready", s_ready, m_ready);
  end

  initial begin
    resetn          = 1'b0;
    cfg_chan_en     = 2'b11;
    cfg_pad_repeat  = 1'b0;
    cfg_count_clear = 1'b0;
    tx_active       = 1'b0;
    s_valid         = 1'b0;
    s_data          = '0;
    m_ready         = 1'b1;
    m_room          = '0;
    #3;
    chk("rst_count", status_underflow_count, 0);
    chk("rst_starved", status_starved, 0);
    chk("rst_underflow", dac_underflow, 0);
    chk("rst_m_valid", m_valid, 0);
    #9 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Passthrough and lane masking
    tx_active   = 1'b1;
    cfg_chan_en = 2'b01;
    step(1, 64'hAAAA_BBBB_1234_5678, 100, 1, 64'h0000_0000_1234_5678);
    step(1, 64'hDEAD_BEEF_CAFE_F00D, 100, 1, 64'h0000_0000_CAFE_F00D);
    cfg_chan_en = 2'b10;
    step(1, 64'h1111_2222_3333_4444, 0, 1, 64'h1111_2222_0000_0000);
    cfg_chan_en = 2'b11;
    step(0, 64'h0, 100, 0, 64'h0);
    chk("run_no_event", status_underflow_count, 0);

    // Starvation with zero pads: one pulse over five cycles
    step(0, 64'h0, 510, 0, 64'h0);
    step(0, 64'h0, 510, 1, 64'h0);
    chk("starve_pulse", dac_underflow, 1);
    chk("starve_flag", status_starved, 1);
    chk("starve_count", status_underflow_count, 1);
    step(0, 64'h0, 510, 1, 64'h0);
    chk("starve_pulse_once", dac_underflow, 0);
    step(0, 64'h0, 510, 1, 64'h0);
    step(0, 64'h0, 510, 1, 64'h0);
    chk("starve_count_hold", status_underflow_count, 1);
    chk("starve_flag_hold", status_starved, 1);

    // Recovery, then re-entry with repeat pads
    step(1, 64'h0001_0002_0003_0004, 510, 1, 64'h0001_0002_0003_0004);
    chk("recover_flag", status_starved, 0);
    chk("recover_pulse", dac_underflow, 0);
    cfg_pad_repeat = 1'b1;
    step(0, 64'h0, 510, 1, 64'h0001_0002_0003_0004);
    chk("reentry_pulse", dac_underflow, 1);
    chk("reentry_count", status_underflow_count, 2);
    chk("reentry_flag", status_starved, 1);
    step(0, 64'h0, 510, 1, 64'h0001_0002_0003_0004);
    chk("reentry_pulse_once", dac_underflow, 0);

    // Leaving the transmission: repeat pads fall back to zero, idle pads are not events
    tx_active = 1'b0;
    step(0, 64'h0, 510, 1, 64'h0001_0002_0003_0004);
    chk("idle_flag", status_starved, 0);
    step(0, 64'h0, 510, 1, 64'h0);
    step(0, 64'h0, 510, 1, 64'h0);
    chk("idle_no_pulse", dac_underflow, 0);
    chk("idle_count", status_underflow_count, 2);

    // Saturation on the 2-bit counter instance
    cfg_pad_repeat = 1'b0;
    tx_active      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1, 64'h0BAD_0000_0000_0000 + 64'(i), 510, 1, 64'h0BAD_0000_0000_0000 + 64'(i));
      step(0, 64'h0, 510, 1, 64'h0);
      chk("sat_pulse", dac_underflow, 1);
      chk("main_count", status_underflow_count, 64'(3 + i));
      chk("sat_count", sat_count, 3);
    end

    // Clear on the same cycle as an event: increment is lost
    step(1, 64'h7777_8888_9999_AAAA, 510, 1, 64'h7777_8888_9999_AAAA);
    cfg_count_clear = 1'b1;
    step(0, 64'h0, 510, 1, 64'h0);
    cfg_count_clear = 1'b0;
    chk("clear_pulse", dac_underflow, 1);
    chk("clear_count", status_underflow_count, 0);
    chk("clear_sat_count", sat_count, 0);

    // Asynchronous reset while starved with a repeat sample held
    step(1, 64'h5555_6666_7777_8888, 510, 1, 64'h5555_6666_7777_8888);
    cfg_pad_repeat = 1'b1;
    step(0, 64'h0, 510, 1, 64'h5555_6666_7777_8888);
    chk("pre_rst_flag", status_starved, 1);
    chk("pre_rst_count", status_underflow_count, 1);
    #2 resetn = 1'b0;
    tx_active = 1'b0;
    #1;
    chk("async_flag", status_starved, 0);
    chk("async_count", status_underflow_count, 0);
    chk("async_pulse", dac_underflow, 0);
    chk("async_m_valid", m_valid, 0);
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_pulse", dac_underflow, 0);
    step(0, 64'h0, 510, 1, 64'h0);
    chk("post_rst_pulse2", dac_underflow, 0);
    chk("post_rst_flag", status_starved, 0);
    step(0, 64'h0, 0, 1, 64'h0);
    step(0, 64'h0, 0, 0, 64'h0);
    step(0, 64'h0, 0, 0, 64'h0);

    chk("leftover_expected", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
